// File: rtl/multicycle_control_if.sv
// Bundles the datapath status inputs and control outputs of the multicycle controller.
// The master modport is the datapath side; the slave modport is the controller itself.
interface multicycle_control_if #(
  parameter int RETIRE_W = 16
);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                reg_write;
  logic                memto_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_control;
  logic [1:0]          pc_source;
  logic                err;
  logic [3:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport master (
    output op, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
           memto_reg, alu_src_a, alu_src_b, alu_control, pc_source, err, state, retired
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
           memto_reg, alu_src_a, alu_src_b, alu_control, pc_source, err, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory-wait timeout, sticky error state
// and a retired-instruction counter.
module multicycle_control #(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 8,
  parameter int RETIRE_W  = 16
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_AEX    = 4'd9,
    S_AWB    = 4'd10,
    S_JMP    = 4'd11,
    S_ERR    = 4'd12
  } state_t;

  localparam bit                 LP_TO_EN = (TIMEOUT > 0);
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                r_state;
  state_t                w_next;
  logic [TIMEOUT_W-1:0]  r_wait;
  logic [TIMEOUT_W-1:0]  w_wait_next;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  w_retire;
  logic                  w_mem_state;
  logic                  w_mem_wait;
  logic                  w_timeout;

  logic       w_pc_write, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_reg_dst, w_reg_write, w_memto_reg, w_alu_src_a, w_err;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic [2:0] w_alu_control;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
      default:                                               funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b000;
    endcase
  endfunction

  // The wait counter only runs while a memory access is pending.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_mem_wait  = w_mem_state && !bus.mem_ready;
  assign w_timeout   = LP_TO_EN && w_mem_wait && (r_wait == LP_LAST);
  assign w_wait_next = w_mem_wait ? (r_wait + TIMEOUT_W'(1)) : '0;

  // State, wait counter and retire counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_pc_write    = 1'b0;
    w_iord        = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_dst     = 1'b0;
    w_reg_write   = 1'b0;
    w_memto_reg   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_alu_control = 3'b000;
    w_pc_source   = 2'b00;
    w_err         = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        w_alu_src_b   = 2'b01;
        w_alu_control = 3'b010;
        // Reset holds the FSM here; memory completion must not load PC/IR then.
        w_ir_write    = bus.mem_ready & i_rst_n;
        w_pc_write    = bus.mem_ready & i_rst_n;
        if (bus.mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b   = 2'b11;
        w_alu_control = 3'b010;
        case (bus.op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = funct_legal(bus.funct) ? S_REX : S_ERR;
          6'b000100:            w_next = S_BEQ;
          6'b001000:            w_next = S_AEX;
          6'b000010:            w_next = S_JMP;
          default:              w_next = S_ERR;
        endcase
      end
      S_MEMADR, S_AEX: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b10;
        w_alu_control = 3'b010;
        if (r_state == S_AEX) begin
          w_next = S_AWB;
        end else if (bus.op == 6'b100011) begin
          w_next = S_MEMRD;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        w_memto_reg = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_AWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_REX: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = funct_alu(bus.funct);
        w_next        = S_RWB;
      end
      S_BEQ: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = 3'b110;
        w_pc_source   = 2'b01;
        w_pc_write    = bus.zero;
        w_next        = S_FETCH;
        w_retire      = 1'b1;
      end
      S_JMP: begin
        w_pc_source = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_ERR;
      end
      default: begin
        w_err  = 1'b1;
        w_next = S_ERR;
      end
    endcase
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.iord        = w_iord;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.reg_write   = w_reg_write;
  assign bus.memto_reg   = w_memto_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.pc_source   = w_pc_source;
  assign bus.err         = w_err;
  assign bus.state       = r_state;
  assign bus.retired     = r_retired;

endmodule
